// File: rtl/multi_issue_queue_pkg.sv
// Shared types and default sizes for the multi-issue queue.
// Contents: default geometry (IQ_DEPTH, IQ_PUSH_W, IQ_POP_W, IQ_DATA_W),
// element, count and pointer types, and a boolean type.
package multi_issue_queue_pkg;

  localparam int unsigned IQ_DEPTH  = 16;
  localparam int unsigned IQ_PUSH_W = 4;
  localparam int unsigned IQ_POP_W  = 2;
  localparam int unsigned IQ_DATA_W = 64;

  typedef logic [IQ_DATA_W-1:0]          issue_queue_element_t;
  typedef logic [$clog2(IQ_DEPTH+1)-1:0] iq_addr_t;
  typedef logic [$clog2(IQ_DEPTH)-1:0]   iq_ptr_t;
  typedef enum logic {FALSE = 1'b0, TRUE = 1'b1} bool_t;

endpackage

// File: rtl/multi_issue_queue_iq_stats.sv
// Occupancy statistics for the issue queue: high-water mark of occupancy and
// a saturating count of rejected push groups.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         clears the high-water mark (reject count is kept)
//   count_next    occupancy the queue will hold after this edge
//   reject_evt    a non-empty push group was refused this cycle
//   high_water    registered maximum occupancy since reset or flush
//   reject_count  registered saturating reject counter (reset only)
module iq_stats #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [$clog2(DEPTH+1)-1:0] count_next,
  input  logic                       reject_evt,
  output logic [$clog2(DEPTH+1)-1:0] high_water,
  output logic [15:0]                reject_count
);

  // High-water mark follows the post-update occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      high_water <= '0;
    end else if (count_next > high_water) begin
      high_water <= count_next;
    end
  end

  // Reject counter survives flush and saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      reject_count <= '0;
    end else if (reject_evt && (reject_count != 16'hFFFF)) begin
      reject_count <= reject_count + 16'd1;
    end
  end

endmodule

// File: rtl/multi_issue_queue.sv
// Circular multi-issue queue between decode and issue. Accepts up to PUSH_W
// entries per cycle as an all-or-nothing group and presents up to POP_W
// entries in program order, with pop requests clamped to what is present.
// Optional macro: IQ_OCCUPANCY_STATS_EN enables high-water / reject statistics;
// when undefined those ports read 0.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop all entries at the next edge
//   in_data           PUSH_W push lanes, lane 0 oldest
//   in_data_number    valid push lanes counted from lane 0
//   push_accepted     combinational: push group taken this cycle
//   iq_size_left      registered free entries
//   iq_size           combinational min(count, POP_W)
//   out_data          POP_W lanes, lane 0 = head
//   out_data_number   entries consumed by issue this cycle
//   iq_high_water     peak occupancy since reset/flush (stats)
//   iq_reject_count   saturating reject count (stats)
module multi_issue_queue
  import multi_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = IQ_DEPTH,
  parameter int unsigned PUSH_W = IQ_PUSH_W,
  parameter int unsigned POP_W  = IQ_POP_W,
  parameter int unsigned DATA_W = IQ_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [PUSH_W*DATA_W-1:0]    in_data,
  input  logic [$clog2(PUSH_W+1)-1:0] in_data_number,
  output logic                        push_accepted,
  output logic [$clog2(DEPTH+1)-1:0]  iq_size_left,
  output logic [$clog2(POP_W+1)-1:0]  iq_size,
  output logic [POP_W*DATA_W-1:0]     out_data,
  input  logic [$clog2(POP_W+1)-1:0]  out_data_number,
  output logic [$clog2(DEPTH+1)-1:0]  iq_high_water,
  output logic [15:0]                 iq_reject_count
);

  localparam int unsigned AW = $clog2(DEPTH+1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NW = $clog2(PUSH_W+1);
  localparam int unsigned OW = $clog2(POP_W+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [AW-1:0]     count;
  logic [AW-1:0]     count_next;
  logic [AW-1:0]     left_q;
  logic [AW-1:0]     push_n;
  logic [OW-1:0]     size_c;
  logic [OW-1:0]     pop_eff;

  // Presented size, clamped pop and the accept decision (pre-pop free space).
  always_comb begin
    size_c        = (count >= AW'(POP_W)) ? OW'(POP_W) : OW'(count);
    pop_eff       = (out_data_number < size_c) ? out_data_number : size_c;
    push_accepted = !flush && (AW'(in_data_number) <= left_q);
    push_n        = push_accepted ? AW'(in_data_number) : '0;
    count_next    = count + push_n - AW'(pop_eff);
  end

  assign iq_size      = size_c;
  assign iq_size_left = left_q;

  // Pointer / occupancy state; flush behaves like reset for these.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      left_q <= AW'(DEPTH);
    end else begin
      head   <= head + PW'(pop_eff);
      tail   <= tail + PW'(push_n);
      count  <= count_next;
      left_q <= AW'(DEPTH) - count_next;
    end
  end

  // Storage is not reset; each accepted lane lands at tail+i with wrap.
  always_ff @(posedge clk) begin
    if (!rst && push_accepted) begin
      for (int i = 0; i < PUSH_W; i++) begin
        if (NW'(i) < in_data_number) begin
          mem[tail + PW'(i)] <= in_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Head window read, wrapping per lane.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < POP_W; j++) begin
      out_data[j*DATA_W +: DATA_W] = mem[head + PW'(j)];
    end
  end

`ifdef IQ_OCCUPANCY_STATS_EN
  logic reject_evt;

  assign reject_evt = !push_accepted && (in_data_number != '0) && !flush;

  iq_stats #(
    .DEPTH (DEPTH)
  ) u_iq_stats (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .count_next   (count_next),
    .reject_evt   (reject_evt),
    .high_water   (iq_high_water),
    .reject_count (iq_reject_count)
  );
`else
  assign iq_high_water   = '0;
  assign iq_reject_count = '0;
`endif

endmodule

// File: tb/tb_multi_issue_queue.sv
module tb_multi_issue_queue;

`ifdef IQ_OCCUPANCY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [255:0] in_data;
  logic [2:0]   in_data_number;
  logic         push_accepted;
  logic [4:0]   iq_size_left;
  logic [1:0]   iq_size;
  logic [127:0] out_data;
  logic [1:0]   out_data_number;
  logic [4:0]   iq_high_water;
  logic [15:0]  iq_reject_count;

  int checks = 0;
  int errors = 0;

  multi_issue_queue dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_data         (in_data),
    .in_data_number  (in_data_number),
    .push_accepted   (push_accepted),
    .iq_size_left    (iq_size_left),
    .iq_size         (iq_size),
    .out_data        (out_data),
    .out_data_number (out_data_number),
    .iq_high_water   (iq_high_water),
    .iq_reject_count (iq_reject_count)
  );

  always #5 clk = ~clk;

  // Drive inputs just after an edge and let combinational outputs settle.
  task automatic drive(input int n, input logic [63:0] base, input int pop, input bit fl);
    for (int i = 0; i < 4; i++) begin
      in_data[i*64 +: 64] = (i < n) ? base + 64'(i) : 64'hDEAD_BEEF;
    end
    in_data_number  = 3'(n);
    out_data_number = 2'(pop);
    flush           = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 64'h0, 0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (iq_size_left !== 5'd16) begin
      $display("FAIL reset_size_left: got %0d expected 16", iq_size_left); errors++;
    end
    checks++;
    if (iq_size !== 2'd0) begin
      $display("FAIL reset_size: got %0d expected 0", iq_size); errors++;
    end
    checks++;
    if (iq_reject_count !== 16'd0 || iq_high_water !== 5'd0) begin
      $display("FAIL reset_stats: got hw=%0d rej=%0d expected 0 0", iq_high_water, iq_reject_count); errors++;
    end
  endtask

  task automatic test_push_basic();
    drive(4, 64'd1, 0, 1'b0);
    checks++;
    if (push_accepted !== 1'b1) begin
      $display("FAIL push4_accept: got %0b expected 1", push_accepted); errors++;
    end
    tick();
    idle();
    checks++;
    if (iq_size_left !== 5'd12) begin
      $display("FAIL push4_left: got %0d expected 12", iq_size_left); errors++;
    end
    checks++;
    if (iq_size !== 2'd2) begin
      $display("FAIL push4_size: got %0d expected 2", iq_size); errors++;
    end
    checks++;
    if (out_data[63:0] !== 64'd1 || out_data[127:64] !== 64'd2) begin
      $display("FAIL push4_out: got %0h,%0h expected 1,2", out_data[63:0], out_data[127:64]); errors++;
    end
  endtask

  task automatic test_full_push_pop();
    for (int k = 0; k < 3; k++) begin
      drive(4, 64'(5 + 4*k), 0, 1'b0);
      tick();
    end
    idle();
    checks++;
    if (iq_size_left !== 5'd0) begin
      $display("FAIL fill_left: got %0d expected 0", iq_size_left); errors++;
    end
    drive(1, 64'd99, 2, 1'b0);
    checks++;
    if (push_accepted !== 1'b0) begin
      $display("FAIL full_push_accept: got %0b expected 0", push_accepted); errors++;
    end
    tick();
    idle();
    checks++;
    if (iq_size_left !== 5'd2) begin
      $display("FAIL full_pop_left: got %0d expected 2", iq_size_left); errors++;
    end
    checks++;
    if (out_data[63:0] !== 64'd3) begin
      $display("FAIL full_pop_head: got %0h expected 3", out_data[63:0]); errors++;
    end
    checks++;
    if (iq_reject_count !== (STATS ? 16'd1 : 16'd0)) begin
      $display("FAIL full_reject_count: got %0d expected %0d", iq_reject_count, STATS ? 1 : 0); errors++;
    end
    checks++;
    if (iq_high_water !== (STATS ? 5'd16 : 5'd0)) begin
      $display("FAIL full_high_water: got %0d expected %0d", iq_high_water, STATS ? 16 : 0); errors++;
    end
  endtask

  task automatic test_reject_retry();
    drive(3, 64'd17, 0, 1'b0);
    checks++;
    if (push_accepted !== 1'b0) begin
      $display("FAIL retry_reject: got %0b expected 0", push_accepted); errors++;
    end
    tick();
    drive(0, 64'h0, 2, 1'b0);
    tick();
    idle();
    checks++;
    if (iq_size_left !== 5'd4) begin
      $display("FAIL retry_pop_left: got %0d expected 4", iq_size_left); errors++;
    end
    drive(3, 64'd17, 0, 1'b0);
    checks++;
    if (push_accepted !== 1'b1) begin
      $display("FAIL retry_accept: got %0b expected 1", push_accepted); errors++;
    end
    tick();
    idle();
    checks++;
    if (iq_size_left !== 5'd1) begin
      $display("FAIL retry_left: got %0d expected 1", iq_size_left); errors++;
    end
    checks++;
    if (out_data[63:0] !== 64'd5 || out_data[127:64] !== 64'd6) begin
      $display("FAIL retry_out: got %0h,%0h expected 5,6", out_data[63:0], out_data[127:64]); errors++;
    end
    checks++;
    if (iq_reject_count !== (STATS ? 16'd2 : 16'd0)) begin
      $display("FAIL retry_reject_count: got %0d expected %0d", iq_reject_count, STATS ? 2 : 0); errors++;
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(4, 64'(100 + 4*k), 0, 1'b0);
      tick();
    end
    drive(2, 64'd112, 0, 1'b0);
    tick();
    for (int k = 0; k < 7; k++) begin
      drive(0, 64'h0, 2, 1'b0);
      tick();
    end
    idle();
    checks++;
    if (iq_size_left !== 5'd16 || iq_size !== 2'd0) begin
      $display("FAIL wrap_drain: got left=%0d size=%0d expected 16 0", iq_size_left, iq_size); errors++;
    end
    drive(4, 64'h200, 0, 1'b0);
    tick();
    idle();
    checks++;
    if (iq_size_left !== 5'd12) begin
      $display("FAIL wrap_push_left: got %0d expected 12", iq_size_left); errors++;
    end
    checks++;
    if (out_data[63:0] !== 64'h200 || out_data[127:64] !== 64'h201) begin
      $display("FAIL wrap_out0: got %0h,%0h expected 200,201", out_data[63:0], out_data[127:64]); errors++;
    end
    drive(0, 64'h0, 2, 1'b0);
    tick();
    idle();
    checks++;
    if (out_data[63:0] !== 64'h202 || out_data[127:64] !== 64'h203) begin
      $display("FAIL wrap_out1: got %0h,%0h expected 202,203", out_data[63:0], out_data[127:64]); errors++;
    end
  endtask

  task automatic test_pop_clamp();
    drive(0, 64'h0, 1, 1'b0);
    tick();
    idle();
    checks++;
    if (iq_size !== 2'd1 || out_data[63:0] !== 64'h203) begin
      $display("FAIL clamp_one_left: got size=%0d head=%0h expected 1 203", iq_size, out_data[63:0]); errors++;
    end
    drive(0, 64'h0, 2, 1'b0);
    tick();
    idle();
    checks++;
    if (iq_size !== 2'd0 || iq_size_left !== 5'd16) begin
      $display("FAIL clamp_empty: got size=%0d left=%0d expected 0 16", iq_size, iq_size_left); errors++;
    end
  endtask

  task automatic test_flush();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(4, 64'(4*k), 0, 1'b0);
      tick();
    end
    drive(1, 64'd77, 2, 1'b0);
    tick();
    drive(0, 64'h0, 0, 1'b1);
    tick();
    drive(4, 64'h300, 0, 1'b0);
    tick();
    drive(4, 64'h304, 0, 1'b0);
    tick();
    drive(1, 64'h308, 0, 1'b0);
    tick();
    idle();
    checks++;
    if (iq_size_left !== 5'd7) begin
      $display("FAIL flush_pre_left: got %0d expected 7", iq_size_left); errors++;
    end
    checks++;
    if (iq_high_water !== (STATS ? 5'd9 : 5'd0)) begin
      $display("FAIL flush_pre_hw: got %0d expected %0d", iq_high_water, STATS ? 9 : 0); errors++;
    end
    drive(4, 64'h400, 2, 1'b1);
    checks++;
    if (push_accepted !== 1'b0) begin
      $display("FAIL flush_push_accept: got %0b expected 0", push_accepted); errors++;
    end
    tick();
    idle();
    checks++;
    if (iq_size_left !== 5'd16 || iq_size !== 2'd0) begin
      $display("FAIL flush_state: got left=%0d size=%0d expected 16 0", iq_size_left, iq_size); errors++;
    end
    checks++;
    if (iq_high_water !== 5'd0) begin
      $display("FAIL flush_hw: got %0d expected 0", iq_high_water); errors++;
    end
    checks++;
    if (iq_reject_count !== (STATS ? 16'd1 : 16'd0)) begin
      $display("FAIL flush_reject_kept: got %0d expected %0d", iq_reject_count, STATS ? 1 : 0); errors++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (iq_reject_count !== 16'd0) begin
      $display("FAIL rst_reject_clear: got %0d expected 0", iq_reject_count); errors++;
    end
  endtask

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    in_data         = '0;
    in_data_number  = '0;
    out_data_number = '0;
    test_reset();
    test_push_basic();
    test_full_push_pop();
    test_reject_retry();
    test_wrap();
    test_pop_clamp();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_issue_queue.md
Name: multi_issue_queue

Overview:
- Parametrised circular issue queue sitting between decode and issue in the MeMIPS pipeline.
- Generalises the fixed 4-in/2-out queue to arbitrary depth, push width, pop width and element width.
- Adds all-or-nothing push acceptance, a pipeline flush, and pop clamping.
- Entries leave in program order.

Parameters:
DEPTH, 16, number of entries; power of two, >= PUSH_W and >= POP_W
PUSH_W, 4, maximum entries pushed per cycle
POP_W, 2, maximum entries popped per cycle
DATA_W, 64, width of one element; width of ISSUE_QUEUE_ELEMENT

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  drop all entries at the next edge
in_data  in  PUSH_W*DATA_W  push lanes; lane 0 is the oldest
in_data_number  in  $clog2(PUSH_W+1)  number of valid push lanes, counted from lane 0
push_accepted  out  1  combinational: this cycle's push is taken
iq_size_left  out  $clog2(DEPTH+1)  registered: DEPTH - count
iq_size  out  $clog2(POP_W+1)  combinational from count: min(count, POP_W) entries presented
out_data  out  POP_W*DATA_W  lane 0 = head; lanes >= iq_size are don't-care
out_data_number  in  $clog2(POP_W+1)  entries consumed by issue this cycle
iq_high_water  out  $clog2(DEPTH+1)  maximum occupancy since reset or flush (see Optional Feature)
iq_reject_count  out  16  rejected pushes, saturating (see Optional Feature)

Behaviour:
- State:
  - Storage: DEPTH x DATA_W.
  - head and tail pointers, $clog2(DEPTH) bits each; wrap modulo DEPTH is natural overflow.
  - count, $clog2(DEPTH+1) bits.
- Reset (rst=1 at an edge):
  - head=tail=count=0, so iq_size_left=DEPTH and iq_size=0.
  - Stats registers are cleared.
  - Storage contents are not reset.
  - Reset overrides flush, push and pop.
- Flush (rst=0, flush=1):
  - Same as reset, except iq_reject_count is kept.
  - Flush overrides push and pop in the same cycle, and push_accepted is forced to 0.
- Push:
  - push_accepted = !flush && (in_data_number <= iq_size_left).
  - The check uses the pre-pop occupancy; space freed by a same-cycle pop is not visible until the next cycle.
  - If accepted, lane i (i < in_data_number) is written to storage[tail+i], and tail advances by in_data_number.
  - If rejected, nothing is written. Decode must re-present the whole group; partial pushes never occur.
  - in_data_number=0 always counts as accepted and is not counted as a reject.
- Pop:
  - Effective pop = min(out_data_number, iq_size); larger requests are clamped silently.
  - head advances by the effective pop.
  - out_data lane j = storage[head+j], combinational read, zero latency from entry to visibility in the cycle after the write.
- Count update: count_next = count + (accepted ? in_data_number : 0) - effective pop.
  - It can never underflow or exceed DEPTH.
- Simultaneous push and pop with count=DEPTH:
  - Push is rejected (pre-pop check); the pop proceeds.
- Wrap-around:
  - A push or pop group may straddle index DEPTH-1 to 0; the indices wrap per lane.
- Latency:
  - An entry pushed at edge N is visible on out_data from cycle N+1.
  - Entries are never bypassed in the cycle they are pushed.

Optional Feature:
- Macro: IQ_OCCUPANCY_STATS_EN.
- Defined:
  - iq_high_water is a register, updated to max(iq_high_water, count_next) each edge; it is cleared by reset and by flush.
  - iq_reject_count is a register, incremented on every cycle with push_accepted=0 && in_data_number!=0 && !flush; it saturates at 16'hFFFF and is cleared by reset only.
- Undefined:
  - Both ports are tied to 0 and no stats registers are instantiated.
  - All other behaviour is identical.

Decomposition:
- defines.svh package holds:
  - ISSUE_QUEUE_ELEMENT (DATA_W wide)
  - IQ_DEPTH, IQ_PUSH_W, IQ_POP_W defaults
  - IQ_ADDR (count type)
  - IQ_PTR (pointer type)
  - bool
- Sub-module iq_stats contains the high-water and reject counters, instantiated only under IQ_OCCUPANCY_STATS_EN.
- Pointer and count arithmetic stays in the top block.

Test Plan:
1. Reset, then push 4 (A,B,C,D) -> next cycle iq_size_left=12, iq_size=2, out_data={B,A}.
2. Fill to 16, then push 1 with a simultaneous pop of 2 -> push_accepted=0, count=14, reject_count=1 (with the stats macro defined).
3. Occupancy 14, push 3 -> rejected; after a pop of 2, push 3 -> accepted, count=15.
4. Wrap: drive head=tail=14 via 14 pushes/pops, push 4 -> entries land at 14,15,0,1 and pop out in order.
5. count=1, out_data_number=2 -> effective pop 1, count=0, iq_size=0.
6. count=9, high_water=9; flush with push 4 asserted -> count=0, iq_size_left=16, push_accepted=0, high_water=0, reject_count kept; rst then clears reject_count.
